// File: rtl/code_to_onehot_driver.sv
// Replays buffered 2-bit encoder codes as timed one-hot drives on a 4-line bus.
// A small FIFO takes entries over a valid/ready handshake; an FSM pops them and holds each drive.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing in flight; loads the next entry as soon as one is buffered
// S_DRIVE | pattern on w, hold counter running down to zero
// S_GAP   | w cleared between slots, gap counter running down to zero
module code_to_onehot_driver #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [1:0]               in_code,
  input  logic                     in_active,
  output logic                     in_ready,
  output logic [3:0]               w,
  output logic                     w_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  state_t        r_state;
  logic [3:0]    r_w;
  logic          r_wv;
  logic [HW-1:0] r_hold;
  logic [GW-1:0] r_gap;

  state_t        w_state_nxt;
  logic [3:0]    w_w_nxt;
  logic          w_wv_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_free;
  logic          w_nonempty;
  logic [2:0]    w_entry;
  logic [3:0]    w_decoded;

  // Ready comes from the registered level only, so a pop never frees a slot in the same cycle.
  assign in_ready   = (r_level != LW'(DEPTH));
  assign w_nonempty = (r_level != '0);
  assign w_push     = in_valid && in_ready && !clr;
  assign w_entry    = r_mem[r_rd_ptr];
  assign w_decoded  = w_entry[2] ? (4'b0001 << w_entry[1:0]) : 4'b0000;

  assign w       = r_w;
  assign w_valid = r_wv;
  assign level   = r_level;
  assign busy    = w_nonempty || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_active, in_code};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_wv_nxt    = r_wv;
    w_hold_nxt  = r_hold;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    w_slot_free = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_slot_free = 1'b1;
      end
      S_DRIVE: begin
        if (r_hold != '0) begin
          w_hold_nxt = r_hold - HW'(1);
        end else if (GAP > 0) begin
          w_w_nxt     = 4'b0000;
          w_wv_nxt    = 1'b0;
          w_gap_nxt   = GW'(GAP - 1);
          w_state_nxt = S_GAP;
        end else begin
          w_slot_free = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - GW'(1);
        end else begin
          w_slot_free = 1'b1;
        end
      end
      default: begin
        w_slot_free = 1'b1;
      end
    endcase

    // A finished slot behaves exactly like IDLE in the same cycle, giving back-to-back loads.
    if (w_slot_free) begin
      if (w_nonempty) begin
        w_pop       = 1'b1;
        w_w_nxt     = w_decoded;
        w_wv_nxt    = 1'b1;
        w_hold_nxt  = HW'(HOLD - 1);
        w_state_nxt = S_DRIVE;
      end else begin
        w_w_nxt     = 4'b0000;
        w_wv_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_state  <= S_IDLE;
      r_w      <= 4'b0000;
      r_wv     <= 1'b0;
      r_hold   <= '0;
      r_gap    <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_state  <= S_IDLE;
      r_w      <= 4'b0000;
      r_wv     <= 1'b0;
      r_hold   <= '0;
      r_gap    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_wv    <= w_wv_nxt;
      r_hold  <= w_hold_nxt;
      r_gap   <= w_gap_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_code_to_onehot_driver.sv
// Directed bench for code_to_onehot_driver: a per-cycle vector table plus hand-written
// sequences for backpressure, zero-gap streaming, flush and asynchronous reset.
module tb_code_to_onehot_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'd0;
  logic       in_active = 1'b0;

  logic       rdy0, rdy1;
  logic [3:0] w0, w1;
  logic       wv0, wv1, busy0, busy1;
  logic [2:0] lvl0, lvl1;

  code_to_onehot_driver #(.DEPTH(4), .HOLD(2), .GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_code(in_code),
    .in_active(in_active), .in_ready(rdy0), .w(w0), .w_valid(wv0), .busy(busy0), .level(lvl0)
  );

  code_to_onehot_driver #(.DEPTH(4), .HOLD(1), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_code(in_code),
    .in_active(in_active), .in_ready(rdy1), .w(w1), .w_valid(wv1), .busy(busy1), .level(lvl1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic       act;
    logic [3:0] ew;
    logic       ewv;
    logic [2:0] elvl;
    logic       ebusy;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  logic       mon_en = 1'b0;
  logic       prev_wv = 1'b0;
  logic [3:0] starts [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (wv0 && !prev_wv) starts.push_back(w0);
      prev_wv = wv0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    clr       = 1'b0;
    in_code   = 2'd0;
    in_active = 1'b0;
  endtask

  task automatic push(input logic [1:0] code, input logic act);
    in_valid  = 1'b1;
    in_code   = code;
    in_active = act;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic setv(input int i, input logic v, input logic [1:0] code, input logic act,
                      input logic [3:0] ew, input logic ewv, input logic [2:0] elvl,
                      input logic ebusy);
    tbl[i].v = v; tbl[i].code = code; tbl[i].act = act;
    tbl[i].ew = ew; tbl[i].ewv = ewv; tbl[i].elvl = elvl; tbl[i].ebusy = ebusy;
  endtask

  initial begin
    // single push code 2, HOLD=2 GAP=1
    setv(0,  1, 2'd2, 1, 4'b0000, 0, 3'd1, 1);
    setv(1,  0, 2'd0, 0, 4'b0100, 1, 3'd0, 1);
    setv(2,  0, 2'd0, 0, 4'b0100, 1, 3'd0, 1);
    setv(3,  0, 2'd0, 0, 4'b0000, 0, 3'd0, 1);
    setv(4,  0, 2'd0, 0, 4'b0000, 0, 3'd0, 0);
    // back-to-back 3,1,0
    setv(5,  1, 2'd3, 1, 4'b0000, 0, 3'd1, 1);
    setv(6,  1, 2'd1, 1, 4'b1000, 1, 3'd1, 1);
    setv(7,  1, 2'd0, 1, 4'b1000, 1, 3'd2, 1);
    setv(8,  0, 2'd0, 0, 4'b0000, 0, 3'd2, 1);
    setv(9,  0, 2'd0, 0, 4'b0010, 1, 3'd1, 1);
    setv(10, 0, 2'd0, 0, 4'b0010, 1, 3'd1, 1);
    setv(11, 0, 2'd0, 0, 4'b0000, 0, 3'd1, 1);
    setv(12, 0, 2'd0, 0, 4'b0001, 1, 3'd0, 1);
    setv(13, 0, 2'd0, 0, 4'b0001, 1, 3'd0, 1);
    setv(14, 0, 2'd0, 0, 4'b0000, 0, 3'd0, 1);
    setv(15, 0, 2'd0, 0, 4'b0000, 0, 3'd0, 0);
    // inactive slot, code 3
    setv(16, 1, 2'd3, 0, 4'b0000, 0, 3'd1, 1);
    setv(17, 0, 2'd0, 0, 4'b0000, 1, 3'd0, 1);
    setv(18, 0, 2'd0, 0, 4'b0000, 1, 3'd0, 1);
    setv(19, 0, 2'd0, 0, 4'b0000, 0, 3'd0, 1);
    setv(20, 0, 2'd0, 0, 4'b0000, 0, 3'd0, 0);

    // reset state
    idle_in();
    rst_n = 1'b0;
    tick();
    chk("rst_w", w0, 4'b0000);
    chk("rst_wv", wv0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      in_valid  = tbl[i].v;
      in_code   = tbl[i].code;
      in_active = tbl[i].act;
      tick();
      chk($sformatf("tbl%0d_w", i), w0, tbl[i].ew);
      chk($sformatf("tbl%0d_wv", i), wv0, tbl[i].ewv);
      chk($sformatf("tbl%0d_level", i), lvl0, tbl[i].elvl);
      chk($sformatf("tbl%0d_ready", i), rdy0, (tbl[i].elvl != 3'd4));
      chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].ebusy);
    end
    idle_in();

    // fill to DEPTH while draining; fifth offer must wait for a pop to land
    begin
      logic [3:0] exp_starts [7];
      int guard;
      do_reset();
      starts.delete();
      prev_wv = 1'b0;
      mon_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
        push(2'(k % 4), 1'b1);
        tick();
      end
      chk("fill_level_full", lvl0, 3'd4);
      chk("fill_ready_full", rdy0, 1'b0);
      push(2'd2, 1'b1);
      tick();
      chk("fill_held_level", lvl0, 3'd4);
      chk("fill_held_ready", rdy0, 1'b0);
      tick();
      chk("fill_pop_no_accept", lvl0, 3'd3);
      chk("fill_ready_after_pop", rdy0, 1'b1);
      tick();
      chk("fill_accept_after_pop", lvl0, 3'd4);
      idle_in();
      guard = 0;
      while (busy0 && guard < 80) begin
        tick();
        guard++;
      end
      chk("fill_drain_done", busy0, 1'b0);
      mon_en = 1'b0;
      for (int k = 0; k < 7; k++) exp_starts[k] = 4'b0001 << (k % 4);
      chk("fill_slot_count", starts.size(), 7);
      for (int k = 0; k < 7 && k < starts.size(); k++)
        chk($sformatf("fill_slot%0d_w", k), starts[k], exp_starts[k]);
    end

    // HOLD=1 GAP=0: continuous stream
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) push(2'(k), 1'b1);
      else idle_in();
      tick();
      chk($sformatf("g0_c%0d_w", k + 1), w1, (k >= 1 && k <= 4) ? (4'b0001 << (k - 1)) : 4'b0000);
      chk($sformatf("g0_c%0d_wv", k + 1), wv1, (k >= 1 && k <= 4));
    end
    chk("g0_busy_end", busy1, 1'b0);

    // flush mid-drive with a concurrent offer
    begin
      logic [1:0] codes [5];
      logic saw_drive;
      codes[0] = 2'd0; codes[1] = 2'd1; codes[2] = 2'd2; codes[3] = 2'd3; codes[4] = 2'd0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
        push(codes[k], 1'b1);
        tick();
      end
      chk("clr_pre_level", lvl0, 3'd3);
      chk("clr_pre_wv", wv0, 1'b1);
      chk("clr_pre_w", w0, 4'b0010);
      push(2'd3, 1'b1);
      clr = 1'b1;
      tick();
      idle_in();
      chk("clr_level", lvl0, 3'd0);
      chk("clr_w", w0, 4'b0000);
      chk("clr_wv", wv0, 1'b0);
      chk("clr_busy", busy0, 1'b0);
      chk("clr_ready", rdy0, 1'b1);
      saw_drive = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (wv0 || busy0) saw_drive = 1'b1;
      end
      chk("clr_offer_dropped", saw_drive, 1'b0);
    end

    // asynchronous reset mid-drive
    do_reset();
    push(2'd1, 1'b1);
    tick();
    idle_in();
    tick();
    chk("arst_pre_w", w0, 4'b0010);
    chk("arst_pre_wv", wv0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_w", w0, 4'b0000);
    chk("arst_wv", wv0, 1'b0);
    chk("arst_ready", rdy0, 1'b1);
    chk("arst_level", lvl0, 3'd0);
    chk("arst_busy", busy0, 1'b0);
    tick();
    chk("arst_hold_ready", rdy0, 1'b1);
    chk("arst_hold_w", w0, 4'b0000);
    #3 rst_n = 1'b1;
    push(2'd3, 1'b1);
    tick();
    idle_in();
    chk("arst_post_level", lvl0, 3'd1);
    chk("arst_post_w0", w0, 4'b0000);
    tick();
    chk("arst_post_w", w0, 4'b1000);
    chk("arst_post_wv", wv0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
